// File: rtl/byte_word_packer_pkg.sv
// -----------------------------------------------------------------------------
// byte_word_packer_pkg
// Shared sizing for the byte-to-word packer and its output word FIFO.
//   DATA_W      : width of one input byte (arbiter dout width)
//   BYTES       : bytes per output word
//   WORD_W      : packed word width
//   CNT_W       : width of the valid-lane count (1..BYTES)
//   IDX_W       : width of the lane index (0..BYTES-1)
//   OFIFO_DEPTH : output word FIFO depth (power of 2, >= 2)
// -----------------------------------------------------------------------------
package byte_word_packer_pkg;

    localparam int DATA_W      = 8;
    localparam int BYTES       = 4;
    localparam int WORD_W      = DATA_W * BYTES;
    localparam int CNT_W       = $clog2(BYTES) + 1;
    localparam int IDX_W       = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int OFIFO_DEPTH = 4;

    // One FIFO entry: lane count alongside the packed word.
    typedef struct packed {
        logic [CNT_W-1:0]  count;
        logic [WORD_W-1:0] word;
    } word_entry_t;

    localparam int ENTRY_W = $bits(word_entry_t);

endpackage

// File: rtl/byte_word_packer_if.sv
// -----------------------------------------------------------------------------
// byte_word_packer_if
// Groups the byte input stream, flush/overflow control and the word output
// valid/ready handshake of byte_word_packer.
//   master : producer/consumer side (drives bytes, flush, out_ready, clr_ovf)
//   slave  : the packer (drives out_valid, out_data, out_count, overflow)
// -----------------------------------------------------------------------------
interface byte_word_packer_if;
    import byte_word_packer_pkg::*;

    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic                flush;
    logic                out_ready;
    logic                out_valid;
    logic [WORD_W-1:0]   out_data;
    logic [CNT_W-1:0]    out_count;
    logic                overflow;
    logic                clr_ovf;

    modport master (
        output in_valid, in_data, flush, out_ready, clr_ovf,
        input  out_valid, out_data, out_count, overflow
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready, clr_ovf,
        output out_valid, out_data, out_count, overflow
    );

endinterface

// File: rtl/byte_word_packer_word_fifo.sv
// -----------------------------------------------------------------------------
// packer_word_fifo
// First-word-fall-through FIFO for completed {count, word} entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_din (accepted if not full, or if popping this edge)
//   i_din      : entry to write
//   i_pop      : remove head entry (ignored when empty)
//   o_dout     : head entry (valid while !o_empty)
//   o_full     : FIFO holds DEPTH entries
//   o_empty    : FIFO holds no entries
// -----------------------------------------------------------------------------
module packer_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty = (r_occ == '0);
    assign o_full  = (r_occ == OCC_W'(DEPTH));
    assign o_dout  = r_mem[r_rd_ptr];

    // A pop frees the head slot on the same edge, so a full FIFO still accepts
    // a write when it is also being read.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage carries no reset; the head is only observed while non-empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

endmodule

// File: rtl/byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
// Packs consecutive valid bytes from the arbiter into little-endian words
// (first byte in lane 0) and buffers them in a small FWFT output FIFO.
// The input cannot be stalled: a word completed while the FIFO is full and
// not being read is dropped and the sticky overflow flag is raised.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   bus.slave  : in_valid/in_data byte stream, flush, out_valid/out_ready/
//                out_data/out_count word handshake, overflow/clr_ovf
// -----------------------------------------------------------------------------
module byte_word_packer
    import byte_word_packer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    byte_word_packer_if.slave bus
);

    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_pack;
    logic              r_overflow;

    logic [WORD_W-1:0] w_word;
    logic              w_last;
    logic              w_push;
    logic [CNT_W-1:0]  w_push_cnt;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    word_entry_t       w_din;
    word_entry_t       w_head;

    // Current partial word with this cycle's byte merged into its lane, so a
    // completing or flushing push includes the byte arriving on that edge.
    always_comb begin
        w_word = r_pack;
        for (int l = 0; l < BYTES; l++) begin
            if (bus.in_valid && (r_idx == IDX_W'(l))) begin
                w_word[l*DATA_W +: DATA_W] = bus.in_data;
            end
        end
    end

    assign w_last     = bus.in_valid && (r_idx == IDX_W'(BYTES - 1));
    assign w_push     = w_last || (bus.flush && ((r_idx != '0) || bus.in_valid));
    assign w_push_cnt = w_last ? CNT_W'(BYTES)
                               : CNT_W'(r_idx) + CNT_W'(bus.in_valid);
    assign w_pop      = !w_empty && bus.out_ready;
    assign w_drop     = w_push && w_full && !w_pop;

    assign w_din.count = w_push_cnt;
    assign w_din.word  = w_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_pack <= '0;
        end else if (w_push) begin
            // Restart packing whether or not the FIFO took the word.
            r_idx  <= '0;
            r_pack <= '0;
        end else if (bus.in_valid) begin
            r_idx  <= r_idx + IDX_W'(1);
            r_pack <= w_word;
        end
    end

    // Sticky drop flag; a new drop on the clearing edge keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    packer_word_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (OFIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Occupancy is a register, so out_valid follows a push by one edge.
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? '0 : w_head.word;
    assign bus.out_count = w_empty ? '0 : w_head.count;
    assign bus.overflow  = r_overflow;

endmodule
